// File: rtl/photodiode_delay_pkg.sv
// Shared types and constants for the photodiode edge-delay measurement block.
package photodiode_delay_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE,
    DONE
  } state_t;

  localparam int unsigned SYNC_STAGES_DEF  = 2;
  localparam int unsigned CNT_W_DEF        = 12;
  localparam int unsigned COARSE_SHIFT_DEF = 4;
  localparam int unsigned N_PD             = 5;
  localparam int unsigned FIELD_W          = 8;

  localparam logic [FIELD_W-1:0] MISSING_FIELD = 8'hFF;

endpackage

// File: rtl/photodiode_delay_if.sv
// Photodiode levels in, measurement results out.
interface photodiode_delay_if #(
  parameter int unsigned CNT_W = 12
);
  logic [4:0]       PD;
  logic [CNT_W-1:0] PD4_delay;
  logic [31:0]      PD_delays;
  logic             button_activate;

  modport master (output PD, input PD4_delay, PD_delays, button_activate);
  modport slave  (input PD, output PD4_delay, PD_delays, button_activate);
endinterface

// File: rtl/pd_sync_edge.sv
// Multi-flop synchroniser per bit followed by a rising-edge detector.
module pd_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WIDTH       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
  logic [WIDTH-1:0]                  prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
      prev  <= '0;
    end else begin
      chain[0] <= d;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      prev <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~prev;

endmodule

// File: rtl/photodiode_delay.sv
// Measures PD[1..4] rising-edge delays relative to PD[0] and publishes them on completion.
module photodiode_delay
  import photodiode_delay_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned COARSE_SHIFT = COARSE_SHIFT_DEF
) (
  input logic               clk,
  input logic               rst,
  photodiode_delay_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_PD-1:0] level;
  logic [N_PD-1:0] rise;

  pd_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(N_PD)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.PD),
    .level(level),
    .rise (rise)
  );

  state_t                 state, state_next;
  logic [CNT_W-1:0]       cnt, cnt_inc, cap_val;
  logic [4:1][CNT_W-1:0]  d;
  logic [4:1]             flag, cap;
  logic [31:0]            packed_delays;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // cnt_inc is the cycle distance from the reference edge, so captures use it directly
  always_comb begin
    state_next = state;
    cap        = '0;
    cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    cap_val    = (state == MEASURE) ? cnt_inc : '0;
    case (state)
      IDLE: if (level == '0) state_next = ARMED;
      ARMED: begin
        if (rise[0]) begin
          cap        = rise[4:1];
          state_next = rise[4] ? DONE : MEASURE;
        end
      end
      MEASURE: begin
        cap = rise[4:1] & ~flag;
        if (cap[4])                  state_next = DONE;
        else if (cnt_inc == CNT_MAX) state_next = IDLE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      d    <= '0;
      flag <= '0;
    end else begin
      if (state == ARMED) begin
        cnt  <= '0;
        flag <= cap;
      end else if (state == MEASURE) begin
        cnt  <= cnt_inc;
        flag <= flag | cap;
      end
      for (int unsigned n = 1; n <= 4; n++) begin
        if (cap[n]) d[n] <= cap_val;
      end
    end
  end

  always_comb begin
    packed_delays = '0;
    for (int unsigned n = 1; n <= 4; n++) begin
      logic [CNT_W-1:0] sh;
      sh = d[n] >> COARSE_SHIFT;
      packed_delays[(n-1)*FIELD_W +: FIELD_W] = flag[n] ? sh[FIELD_W-1:0] : MISSING_FIELD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.PD4_delay       <= '0;
      bus.PD_delays       <= '0;
      bus.button_activate <= 1'b0;
    end else begin
      bus.button_activate <= (state == DONE);
      if (state == DONE) begin
        bus.PD4_delay <= d[4];
        bus.PD_delays <= packed_delays;
      end
    end
  end

endmodule

// File: tb/tb_photodiode_delay.sv
// Scoreboard bench: stimulus pushes expected results, a monitor checks each completion pulse.
module tb_photodiode_delay;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  photodiode_delay_if #(.CNT_W(12)) bus ();

  photodiode_delay #(.SYNC_STAGES(2), .CNT_W(12), .COARSE_SHIFT(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [11:0] lo;
    logic [11:0] hi;
    logic [31:0] delays;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   fails  = 0;
  int   pulses = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every completion pulse must match the oldest outstanding expectation
  initial begin
    exp_t e;
    bit   prev_btn;
    prev_btn = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_btn = 1'b0;
      end else begin
        if (bus.button_activate) begin
          pulses++;
          if (prev_btn) begin
            tests++;
            fails++;
            $display("FAIL pulse_width: button_activate high for 2+ cycles, required 1");
          end else if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pulse: pulse with PD_delays=0x%08h, required no pulse",
                     bus.PD_delays);
          end else begin
            e = sb.pop_front();
            tests++;
            if (bus.PD4_delay < e.lo || bus.PD4_delay > e.hi) begin
              fails++;
              $display("FAIL pd4_delay: got %0d, required %0d..%0d", bus.PD4_delay, e.lo, e.hi);
            end
            check32("pd_delays", bus.PD_delays, e.delays);
          end
        end
        prev_btn = bus.button_activate;
      end
    end
  end

  task automatic stair(input bit skip2, input bit early1, input int hold_ns);
    exp_t       e;
    logic [4:0] mask, extra, lvl;
    int         gaps[4];
    gaps     = '{2048, 2048, 4096, 4096};
    e.lo     = 12'd1228;
    e.hi     = 12'd1229;
    e.delays = {8'h4C, 8'h33, (skip2 ? 8'hFF : 8'h19), (early1 ? 8'hFF : 8'h0C)};
    sb.push_back(e);
    mask  = skip2  ? 5'b11011 : 5'b11111;
    extra = early1 ? 5'b00010 : 5'b00000;
    if (early1) begin
      bus.PD = extra;
      #500;
    end
    lvl    = 5'b00001;
    bus.PD = (lvl | extra) & mask;
    for (int i = 0; i < 4; i++) begin
      #(gaps[i]);
      lvl    = {lvl[3:0], 1'b1};
      bus.PD = (lvl | extra) & mask;
    end
    #(hold_ns);
    bus.PD = '0;
    #200;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst    = 1'b1;
    bus.PD = 'x;
    #40;
    bus.PD = '0;
    #20;
    rst = 1'b0;
    #20;
    check32("reset_pd4", 32'(bus.PD4_delay), 32'd0);
    check32("reset_delays", bus.PD_delays, 32'd0);
    check32("reset_btn", 32'(bus.button_activate), 32'd0);
    #100;

    stair(1'b0, 1'b0, 24576);
    stair(1'b1, 1'b0, 2000);
    stair(1'b0, 1'b1, 2000);

    e.lo = 12'd0; e.hi = 12'd0; e.delays = 32'h0000_0000;
    sb.push_back(e);
    bus.PD = 5'b11111;
    #2000;
    bus.PD = '0;
    #200;

    // PD[0] only: must abort silently and keep the previous (all-zero) results
    bus.PD = 5'b00001;
    #45000;
    bus.PD = '0;
    #200;
    check32("timeout_pd4", 32'(bus.PD4_delay), 32'd0);
    check32("timeout_delays", bus.PD_delays, 32'd0);
    check32("timeout_pulses", 32'(pulses), 32'd4);

    stair(1'b0, 1'b0, 2000);
    for (int r = 0; r < 20; r++) stair(1'b0, 1'b0, 200);
    check32("repeat_pulses", 32'(pulses), 32'd25);

    bus.PD = 5'b00001;
    #3000;
    rst = 1'b1;
    #20;
    check32("midreset_delays", bus.PD_delays, 32'd0);
    check32("midreset_pd4", 32'(bus.PD4_delay), 32'd0);
    rst    = 1'b0;
    bus.PD = '0;
    #1000;
    check32("midreset_btn", 32'(bus.button_activate), 32'd0);
    check32("sb_empty", 32'(sb.size()), 32'd0);
    check32("final_pulses", 32'(pulses), 32'd25);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/photodiode_delay.md
Name: photodiode_delay

Overview:
- Measures the relative arrival times of rising edges on five photodiode inputs, PD[0] through PD[4].
- PD[0] is the reference edge; PD[1..4] are measured against it.
- One clock domain at 100 MHz; the PD inputs are asynchronous.
- Publishes a full-resolution PD4 delay, a packed coarse delay word, and a one-cycle "measurement complete" strobe for downstream button/trigger logic.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each PD input synchroniser (minimum 2).
- CNT_W, 12, width of the delay counter in clock cycles.
- COARSE_SHIFT, 4, right shift applied to each delay before it is packed into PD_delays.

Ports:
- clk  in  1  system clock, 100 MHz, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- PD  in  5  raw photodiode levels, asynchronous to clk.
- PD4_delay  out  12  cycles from the PD[0] rising edge to the PD[4] rising edge, last completed measurement.
- PD_delays  out  32  packed coarse delays {d4[11:4], d3[11:4], d2[11:4], d1[11:4]}; d1 is in bits [7:0].
- button_activate  out  1  one-cycle pulse when a measurement completes.

Behaviour:
- Reset (async, active-high):
  - PD4_delay, PD_delays and button_activate = 0.
  - FSM goes to IDLE; counter = 0; synchronisers cleared.
- Input conditioning:
  - Each PD bit passes through a SYNC_STAGES flip-flop chain.
  - A rising-edge detector compares the last sync stage with one extra register; a rise gives a one-cycle pulse rise[n].
  - All bits share identical pipeline latency, so measured differences are unaffected by it.
- FSM states:
  - IDLE: wait until all synchronised PD bits are 0, then go to ARMED.
  - ARMED: on rise[0], clear the counter to 0, clear all captured flags, go to MEASURE.
    - rise[1..4] in ARMED are ignored, except when they occur in the same cycle as rise[0]: then that channel captures delay 0.
  - MEASURE:
    - Counter increments by 1 each cycle, saturating at 2^CNT_W-1.
    - On the first rise[n] (n=1..4), latch the current counter value into dn and set flag n. Later rises on that channel are ignored.
    - When flag 4 is set (the PD4 capture cycle), go to DONE.
    - If the counter reaches 4095 without a PD4 capture, abort to IDLE. Outputs stay unchanged and there is no pulse.
  - DONE (one cycle), then IDLE:
    - PD4_delay <= d4.
    - PD_delays <= packed d4..d1 >> COARSE_SHIFT.
    - button_activate = 1 for exactly this cycle.
- Boundary rules:
  - A channel not captured by the time PD4 is captured reports field 0xFF.
  - A delay equal to 0 (same-cycle edge) is legal.
  - A new rise[0] during MEASURE is ignored.
  - PD falling edges have no effect except enabling IDLE->ARMED once all bits are low.
  - Asserting reset mid-measurement discards the measurement and clears the outputs.
- Latency:
  - Outputs update SYNC_STAGES+2 cycles after PD[4] rises at the pin.
  - Outputs hold their value until the next completed measurement.
- Delay resolution: ±1 cycle, due to asynchronous sampling.

Decomposition:
- Package photodiode_delay_pkg:
  - FSM state enum (IDLE, ARMED, MEASURE, DONE).
  - CNT_W / COARSE_SHIFT defaults.
  - Constant MISSING_FIELD = 8'hFF.
- One natural sub-module, pd_sync_edge: the per-bit synchroniser plus rising-edge detector, instantiated 5 times or as a 5-bit vector.

Test Plan:
- Reset: assert rst with PD = X, then release -> all outputs 0, no button_activate pulse.
- Nominal staircase:
  - Stimulus: PD 0 -> 1, then after 2048 ns -> 3, after 4096 ns total -> 7, at 8192 ns -> 15, at 12288 ns -> 31; hold 24576 ns; back to 0.
  - Required: PD4_delay = 1228 or 1229; PD_delays = 0x4C_33_19_0C; one button_activate pulse per cycle.
- Repetition: 100 consecutive staircases -> exactly 100 pulses, all with identical PD_delays = 0x4C33190C.
- Missing channel: same staircase but PD[2] never rises -> field d2 (bits [15:8]) = 0xFF, other fields unchanged, pulse issued.
- Timeout: PD[0] rises, PD[4] never rises for more than 4096 cycles -> no pulse, outputs retain their previous values, and the next valid staircase measures correctly.
- Same-cycle / premature edges:
  - PD jumps 0 -> 31 in one step -> PD4_delay = 0, PD_delays = 0x00000000, pulse issued.
  - PD[1] rising before PD[0] -> ignored, and its later real edge is not captured (field 0xFF).
